// File: rtl/fmeas_pkg.sv
// Shared types and defaults for the frequency-meter channel scheduler.
package fmeas_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StStart,
    StWait,
    StStore,
    StNext,
    StDone
  } fmeas_state_e;

  localparam int unsigned SettleCycDefault  = 16;
  localparam logic [31:0] TimeoutCycDefault = 32'd100_000_000;

  typedef logic [63:0] fmeas_result_t;

endpackage

// File: rtl/fmeas_result_bank.sv
// Per-channel 64-bit result register file: one write port, one registered read port.
module fmeas_result_bank
  import fmeas_pkg::*;
#(
  parameter int unsigned  NCh  = 4,
  localparam int unsigned SelW = $clog2(NCh)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [SelW-1:0] wr_ch_i,
  input  fmeas_result_t wr_data_i,
  input  logic [SelW-1:0] rd_ch_i,
  output fmeas_result_t rd_data_o
);

  fmeas_result_t mem_q [NCh];
  fmeas_result_t mem_d [NCh];
  fmeas_result_t rd_data_q, rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i && (32'(wr_ch_i) < NCh)) begin
      mem_d[wr_ch_i] = wr_data_i;
    end
    // Indices past the last channel read as zero.
    rd_data_d = '0;
    if (32'(rd_ch_i) < NCh) begin
      rd_data_d = mem_q[rd_ch_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/freq_meas_sched.sv
// Scans enabled channels through a shared frequency meter and banks each result.
// Optional measurement timeout enabled by defining FMEAS_TIMEOUT_EN.
module freq_meas_sched
  import fmeas_pkg::*;
#(
  parameter int unsigned  N_CH        = 4,
  parameter int unsigned  SETTLE_CYC  = SettleCycDefault,
  parameter logic [31:0]  TIMEOUT_CYC = TimeoutCycDefault,
  localparam int unsigned SelW        = $clog2(N_CH)
) (
  input  logic            clk_fs,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_CH-1:0] chan_mask,
  output logic            busy,
  output logic            done,
  output logic [SelW-1:0] meas_sel,
  output logic            meas_start,
  input  logic            meas_done,
  input  logic [63:0]     meas_data,
  input  logic [SelW-1:0] rd_ch,
  output logic [63:0]     rd_data,
  output logic [N_CH-1:0] res_valid,
  output logic [N_CH-1:0] res_err
);

  localparam logic [7:0] SettleLast = (SETTLE_CYC == 0)  ? 8'd0  :
                                      (SETTLE_CYC > 256) ? 8'hff : 8'(SETTLE_CYC - 1);
  localparam logic [N_CH-1:0] OneLsb = {{(N_CH-1){1'b0}}, 1'b1};

  fmeas_state_e    state_q, state_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [7:0]      settle_q, settle_d;
  fmeas_result_t   data_q, data_d;
  logic [N_CH-1:0] valid_q, valid_d;
  logic [N_CH-1:0] err_q, err_d;

  logic [SelW-1:0] pick_ch;
  logic [N_CH-1:0] sel_oh;
  logic            bank_we;
  fmeas_result_t   bank_wdata;

`ifdef FMEAS_TIMEOUT_EN
  localparam logic [31:0] TmoLast = (TIMEOUT_CYC == 32'd0) ? 32'd0 : TIMEOUT_CYC - 32'd1;
  logic [31:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // Lowest-index pending channel wins.
  always_comb begin
    pick_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) pick_ch = SelW'(i);
    end
  end

  assign sel_oh = OneLsb << sel_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    sel_d      = sel_q;
    settle_d   = settle_q;
    data_d     = data_q;
    valid_d    = valid_q;
    err_d      = err_q;
    bank_we    = 1'b0;
    bank_wdata = data_q;
`ifdef FMEAS_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pend_d  = chan_mask;
          valid_d = '0;
          err_d   = '0;
          state_d = StNext;
        end
      end
      StNext: begin
        if (|pend_q) begin
          sel_d    = pick_ch;
          pend_d   = pend_q & (pend_q - OneLsb);
          settle_d = '0;
          state_d  = StSelect;
        end else begin
          state_d = StDone;
        end
      end
      StSelect: begin
        if (settle_q >= SettleLast) begin
          state_d = StStart;
        end else if (settle_q != 8'hff) begin
          settle_d = settle_q + 8'd1;
        end
      end
      StStart: begin
`ifdef FMEAS_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        // A result arriving on the timeout cycle still counts.
        if (meas_done) begin
          data_d  = meas_data;
          state_d = StStore;
        end
`ifdef FMEAS_TIMEOUT_EN
        else if (tmo_q >= TmoLast) begin
          bank_we    = 1'b1;
          bank_wdata = '0;
          err_d      = err_q | sel_oh;
          state_d    = StNext;
        end else if (tmo_q != 32'hffff_ffff) begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      StStore: begin
        bank_we    = 1'b1;
        bank_wdata = data_q;
        valid_d    = valid_q | sel_oh;
        state_d    = StNext;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_fs) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      sel_q    <= '0;
      settle_q <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      err_q    <= '0;
`ifdef FMEAS_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef FMEAS_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  fmeas_result_bank #(
    .NCh(N_CH)
  ) u_bank (
    .clk_i    (clk_fs),
    .rst_ni   (rst_n),
    .we_i     (bank_we),
    .wr_ch_i  (sel_q),
    .wr_data_i(bank_wdata),
    .rd_ch_i  (rd_ch),
    .rd_data_o(rd_data)
  );

  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);
  assign meas_start = (state_q == StStart);
  assign meas_sel   = sel_q;
  assign res_valid  = valid_q;
`ifdef FMEAS_TIMEOUT_EN
  assign res_err    = err_q;
`else
  assign res_err    = '0;
`endif

endmodule
